frame_strobe_gen: RTL and testbench
===================================

Name: frame_strobe_gen

Overview:
Upstream configuration stage for a fabric column. It feeds the FrameStrobe bus of the column's tiles, including the south terminal tile that buffers and forwards it, and it feeds the matching FrameData rows.
- Accepts frame-write beats over a valid/ready stream and assembles one full column frame (NumRows words).
- Then pulses exactly one FrameStrobe line for a programmable number of cycles, with FrameData held stable.
- Enforces a dead cycle between frames so strobes never overlap data changes.

Parameters:
MaxFramesPerCol, 20, width of FrameStrobe bus (frames per column)
FrameBitsPerRow, 32, bits per row word
NumRows, 2, rows (words) per column frame
StrobeCycles, 2, cycles FrameStrobe is held high (>=1)

Ports:
UserCLK  in  1  single clock; all logic rising-edge
resetn  in  1  synchronous, active-low reset
s_valid  in  1  beat valid
s_ready  out  1  beat accepted when s_valid&s_ready
s_data  in  FrameBitsPerRow  row word, row 0 first
s_addr  in  $clog2(MaxFramesPerCol)  frame index; sampled on beat 0 only
FrameData  out  NumRows*FrameBitsPerRow  row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
FrameStrobe  out  MaxFramesPerCol  one-hot strobe, else all zero
busy  out  1  high in any state but IDLE
err  out  1  one-cycle pulse, bad address

Behaviour:
- Reset (resetn low at an edge) applies from any state.
  - All outputs reset: s_ready=0 during reset, FrameData=0, FrameStrobe=0, busy=0, err=0.
  - Internal state: state=IDLE, beat count=0.
  - The first cycle after reset releases has s_ready=1.
  - Reset mid-STROBE drops the strobe at that same edge; a partial frame is discarded.
- FSM states: IDLE, LOAD, STROBE, GAP.
- IDLE:
  - s_ready=1.
  - On accept: latch s_addr, write s_data to row 0, beat count=1.
  - If NumRows==1, go to STROBE; else go to LOAD.
- LOAD:
  - s_ready=1.
  - Each accept writes row[count] and increments count.
  - The accept of row NumRows-1 moves to STROBE.
  - s_valid low stalls indefinitely, with no timeout.
  - FrameData rows update as soon as they are written.
- STROBE:
  - s_ready=0.
  - If latched addr<MaxFramesPerCol: FrameStrobe[addr]=1 for exactly StrobeCycles cycles.
  - Else: FrameStrobe stays 0, and err=1 in the first STROBE cycle only.
  - The state still lasts StrobeCycles cycles; then go to GAP.
- GAP:
  - s_ready=0, FrameStrobe=0, FrameData held.
  - Lasts 1 cycle, then go to IDLE.
- Latency: last beat accepted at edge N → FrameStrobe high for cycles N+1 .. N+StrobeCycles. GAP follows; s_ready is high again in cycle N+StrobeCycles+2.
- FrameData changes only in IDLE/LOAD, never while FrameStrobe is nonzero.
- busy is combinational from state (state!=IDLE).
- The strobe counter is $clog2(StrobeCycles+1) bits and counts down. The beat counter is $clog2(NumRows+1) bits. No wrap is possible under legal params.
- s_addr on beats other than 0 is ignored.

Decomposition:
- Shared package: FSM state enum (IDLE, LOAD, STROBE, GAP) and a width-helper function for the address and counter widths.
- One natural sub-module: frame_strobe_decode. It is a registered one-hot decoder with an enable and a range check, producing FrameStrobe and err.

Test Plan:
1. Reset with s_valid=1 held → s_ready=0, FrameStrobe=0, FrameData=0 while resetn=0. s_ready=1 in the first cycle after release.
2. Beats 0xA5A5A5A5 (addr=3) then 0x0F0F0F0F, back-to-back → FrameData=0x0F0F0F0F_A5A5A5A5. FrameStrobe=0x00008 for exactly 2 cycles starting the cycle after beat 1. s_ready=0 for 3 cycles.
3. addr=25 (out of range) → FrameStrobe stays 0, err pulses for 1 cycle, busy lasts LOAD+2+1 cycles, and the next frame is accepted normally.
4. s_valid gaps of 5 cycles between beats → state stays LOAD, no strobe until beat 1. The strobe is still 2 cycles on FrameStrobe[addr].
5. resetn asserted in the 1st STROBE cycle → FrameStrobe=0 and busy=0 the next cycle. A fresh frame afterward strobes correctly.
6. Two frames, addr=0 then addr=19, s_valid held high → strobes 0x00001 then 0x80000, separated by exactly one zero GAP cycle plus the 2 load cycles. FrameData is never changed while a strobe is high.

Source files
------------

// File: rtl/frame_strobe_gen_pkg.sv
// Shared types and helpers for the frame strobe generator.
//   state_e  : controller FSM states
//   width_of : bit width needed to index n values (never below 1)
package frame_strobe_gen_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StStrobe,
    StGap
  } state_e;

  function automatic int unsigned width_of(int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_strobe_gen_if.sv
// Frame-write beat stream (valid/ready).
//   s_valid : beat valid (master -> slave)
//   s_ready : beat accepted when s_valid & s_ready (slave -> master)
//   s_data  : row word, row 0 first
//   s_addr  : frame index, only meaningful on beat 0
interface frame_strobe_gen_if #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5
) ();

  logic                 s_valid;
  logic                 s_ready;
  logic [DataWidth-1:0] s_data;
  logic [AddrWidth-1:0] s_addr;

  modport master (output s_valid, output s_data, output s_addr, input s_ready);
  modport slave  (input s_valid, input s_data, input s_addr, output s_ready);

endinterface

// File: rtl/frame_strobe_decode.sv
// Registered one-hot FrameStrobe decoder with range check.
//   clk_i    : clock
//   rst_ni   : synchronous active-low reset
//   en_i     : strobe is wanted in the next cycle
//   first_i  : next cycle is the first strobe cycle of a frame
//   addr_i   : frame index to decode
//   strobe_o : registered one-hot strobe (all zero when disabled or out of range)
//   err_o    : registered one-cycle pulse for an out-of-range index
module frame_strobe_decode #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned AddrWidth       = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_i,
  input  logic                       first_i,
  input  logic [AddrWidth-1:0]       addr_i,
  output logic [MaxFramesPerCol-1:0] strobe_o,
  output logic                       err_o
);

  logic                       in_range;
  logic [MaxFramesPerCol-1:0] strobe_d;
  logic                       err_d;

  assign in_range = (32'(addr_i) < MaxFramesPerCol);

  always_comb begin
    strobe_d = '0;
    if (en_i && in_range) begin
      strobe_d[addr_i] = 1'b1;
    end
    err_d = first_i & ~in_range;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      strobe_o <= '0;
      err_o    <= 1'b0;
    end else begin
      strobe_o <= strobe_d;
      err_o    <= err_d;
    end
  end

endmodule

// File: rtl/frame_strobe_gen.sv
// Column configuration feeder: assembles NumRows beats into one frame, then
// pulses one FrameStrobe line for StrobeCycles cycles with FrameData stable,
// followed by a single dead (GAP) cycle before the next frame is accepted.
//   UserCLK     : clock, rising edge
//   resetn      : synchronous active-low reset
//   s_if        : beat stream (slave side)
//   FrameData   : row r at [r*FrameBitsPerRow +: FrameBitsPerRow]
//   FrameStrobe : one-hot strobe or all zero
//   busy        : controller not idle
//   err         : one-cycle pulse when the latched frame index is out of range
module frame_strobe_gen
  import frame_strobe_gen_pkg::*;
#(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 2,
  parameter int unsigned StrobeCycles    = 2
) (
  input  logic                               UserCLK,
  input  logic                               resetn,
  frame_strobe_gen_if.slave                  s_if,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic                               err
);

  localparam int unsigned AddrWidth = width_of(MaxFramesPerCol);
  localparam int unsigned BeatWidth = width_of(NumRows + 1);
  localparam int unsigned StrbWidth = width_of(StrobeCycles + 1);

  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(NumRows - 1);
  localparam logic [StrbWidth-1:0] StrbLoad = StrbWidth'(StrobeCycles);
  localparam logic [StrbWidth-1:0] StrbOne  = StrbWidth'(1);

  state_e                     state_q;
  logic [BeatWidth-1:0]       beat_cnt_q;
  logic [StrbWidth-1:0]       strb_cnt_q;
  logic [AddrWidth-1:0]       addr_q;
  logic [FrameBitsPerRow-1:0] rows_q [NumRows];

  logic                 loading;
  logic                 accept;
  logic                 last_beat;
  logic                 strobe_en;
  logic [AddrWidth-1:0] frame_addr;

  assign loading = (state_q == StIdle) || (state_q == StLoad);
  // Gated with resetn so the stream is never offered a ready while held in reset.
  assign s_if.s_ready = resetn & loading;
  assign accept       = s_if.s_valid & s_if.s_ready;
  assign last_beat    = accept && (beat_cnt_q == LastBeat);
  assign busy         = (state_q != StIdle);

  // A single-row frame completes on beat 0, before addr_q has been written.
  assign frame_addr = (state_q == StIdle) ? s_if.s_addr : addr_q;

  // Decoder output is registered, so request the strobe for the coming cycle.
  assign strobe_en = last_beat || ((state_q == StStrobe) && (strb_cnt_q != StrbOne));

  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      state_q    <= StIdle;
      beat_cnt_q <= '0;
      strb_cnt_q <= '0;
      addr_q     <= '0;
      for (int r = 0; r < NumRows; r++) begin
        rows_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NumRows; r++) begin
        if (accept && (beat_cnt_q == BeatWidth'(r))) begin
          rows_q[r] <= s_if.s_data;
        end
      end
      unique case (state_q)
        StIdle, StLoad: begin
          if (accept) begin
            if (state_q == StIdle) begin
              addr_q <= s_if.s_addr;
            end
            if (last_beat) begin
              state_q    <= StStrobe;
              strb_cnt_q <= StrbLoad;
              beat_cnt_q <= '0;
            end else begin
              state_q    <= StLoad;
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        StStrobe: begin
          if (strb_cnt_q == StrbOne) begin
            state_q <= StGap;
          end else begin
            strb_cnt_q <= strb_cnt_q - 1'b1;
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    FrameData = '0;
    for (int r = 0; r < NumRows; r++) begin
      FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] = rows_q[r];
    end
  end

  frame_strobe_decode #(
    .MaxFramesPerCol (MaxFramesPerCol),
    .AddrWidth       (AddrWidth)
  ) u_decode (
    .clk_i    (UserCLK),
    .rst_ni   (resetn),
    .en_i     (strobe_en),
    .first_i  (last_beat),
    .addr_i   (frame_addr),
    .strobe_o (FrameStrobe),
    .err_o    (err)
  );

endmodule

// File: tb/tb_frame_strobe_gen.sv
module tb_frame_strobe_gen;

  localparam int unsigned MaxFrames = 20;

  typedef struct {
    logic        rstn;
    logic        valid;
    logic [31:0] data;
    logic [4:0]  addr;
    logic        ready;
    logic        busy;
    logic        err;
    logic [19:0] strb;
    logic [63:0] fd;
  } vec_t;

  typedef struct {
    logic [19:0] strobe;
    int          len;
    logic [63:0] fd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [63:0] frame_data;
  logic [19:0] frame_strobe;
  logic        busy;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  exp_t sb[$];
  logic mon_en = 1'b0;

  // Monitor state
  int          run_len  = 0;
  int          zero_run = 0;
  int          last_gap = 0;
  logic [19:0] run_val  = '0;
  logic [63:0] run_fd   = '0;
  logic        prev_err = 1'b0;

  frame_strobe_gen_if #(.DataWidth(32), .AddrWidth(5)) s_if ();

  frame_strobe_gen #(
    .MaxFramesPerCol (20),
    .FrameBitsPerRow (32),
    .NumRows         (2),
    .StrobeCycles    (2)
  ) dut (
    .UserCLK     (clk),
    .resetn      (resetn),
    .s_if        (s_if),
    .FrameData   (frame_data),
    .FrameStrobe (frame_strobe),
    .busy        (busy),
    .err         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int addr, input logic [31:0] w0, input logic [31:0] w1,
                                 input int len);
    exp_t e;
    e.fd = {w1, w0};
    if (addr < int'(MaxFrames)) begin
      e.strobe = 20'(1) << addr;
      e.err    = 1'b0;
      e.len    = len;
    end else begin
      e.strobe = '0;
      e.err    = 1'b1;
      e.len    = 0;
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic rstn, input logic valid, input logic [31:0] data,
                              input logic [4:0] addr, input logic ready, input logic bsy,
                              input logic er, input logic [19:0] strb, input logic [63:0] fd);
    vec_t v;
    v.rstn = rstn; v.valid = valid; v.data = data; v.addr = addr;
    v.ready = ready; v.busy = bsy; v.err = er; v.strb = strb; v.fd = fd;
    return v;
  endfunction

  // Scoreboard monitor: each frame yields one event, a completed strobe run or an err pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      if (err) begin
        check("err_pulse_width", {63'd0, prev_err}, 64'd0);
        if (!prev_err) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_err: got err=1 required no pending frame");
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("err_expected", {63'd0, err}, {63'd0, e.err});
            check("err_strobe_zero", {44'd0, frame_strobe}, {44'd0, e.strobe});
          end
        end
      end
      prev_err = err;
      if (frame_strobe != '0) begin
        if (run_len == 0) begin
          run_val  = frame_strobe;
          run_fd   = frame_data;
          last_gap = zero_run;
        end else begin
          check("strobe_stable", {44'd0, frame_strobe}, {44'd0, run_val});
          check("fd_stable_under_strobe", frame_data, run_fd);
        end
        run_len++;
        zero_run = 0;
      end else begin
        zero_run++;
        if (run_len > 0) begin
          if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL unexpected_strobe: got %h required none", run_val);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("strobe_value", {44'd0, run_val}, {44'd0, e.strobe});
            check("strobe_len", 64'(run_len), 64'(e.len));
            check("strobe_fd", run_fd, e.fd);
          end
          run_len = 0;
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!s_if.s_ready && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!s_if.s_ready) begin
      n_vec++; n_err++;
      $display("FAIL ready_timeout: got s_ready=0 required 1 within 30 cycles");
    end
  endtask

  // Called just after a rising edge; returns just after the edge accepting the last beat.
  task automatic send_frame(input int addr, input logic [31:0] w0, input logic [31:0] w1,
                            input int gap, input bit hold, input int len);
    for (int b = 0; b < 2; b++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = (b == 0) ? w0 : w1;
      s_if.s_addr  = (b == 0) ? 5'(addr) : ~5'(addr);
      if (b == 1) sb.push_back(model(addr, w0, w1, len));
      wait_ready();
      @(posedge clk);
      #1;
      if (!(b == 1 && hold)) s_if.s_valid = 1'b0;
      if (b == 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("load_stall_strobe", {44'd0, frame_strobe}, 64'd0);
          check("load_stall_busy", {63'd0, busy}, 64'd1);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = mk(0, 1, 32'hDEADBEEF, 3,  0, 0, 0, 20'h0, 64'h0);
    tbl[1]  = mk(0, 1, 32'hDEADBEEF, 3,  0, 0, 0, 20'h0, 64'h0);
    tbl[2]  = mk(1, 0, 32'h0,        0,  1, 0, 0, 20'h0, 64'h0);
    tbl[3]  = mk(1, 1, 32'hA5A5A5A5, 3,  1, 0, 0, 20'h0, 64'h0);
    tbl[4]  = mk(1, 1, 32'h0F0F0F0F, 7,  1, 1, 0, 20'h0, 64'h00000000_A5A5A5A5);
    tbl[5]  = mk(1, 0, 32'h0,        0,  0, 1, 0, 20'h8, 64'h0F0F0F0F_A5A5A5A5);
    tbl[6]  = mk(1, 1, 32'hFFFFFFFF, 1,  0, 1, 0, 20'h8, 64'h0F0F0F0F_A5A5A5A5);
    tbl[7]  = mk(1, 1, 32'hFFFFFFFF, 1,  0, 1, 0, 20'h0, 64'h0F0F0F0F_A5A5A5A5);
    tbl[8]  = mk(1, 0, 32'h0,        0,  1, 0, 0, 20'h0, 64'h0F0F0F0F_A5A5A5A5);
    tbl[9]  = mk(1, 1, 32'h11111111, 25, 1, 0, 0, 20'h0, 64'h0F0F0F0F_A5A5A5A5);
    tbl[10] = mk(1, 1, 32'h22222222, 2,  1, 1, 0, 20'h0, 64'h0F0F0F0F_11111111);
    tbl[11] = mk(1, 0, 32'h0,        0,  0, 1, 1, 20'h0, 64'h22222222_11111111);
    tbl[12] = mk(1, 0, 32'h0,        0,  0, 1, 0, 20'h0, 64'h22222222_11111111);
    tbl[13] = mk(1, 0, 32'h0,        0,  0, 1, 0, 20'h0, 64'h22222222_11111111);
    tbl[14] = mk(1, 0, 32'h0,        0,  1, 0, 0, 20'h0, 64'h22222222_11111111);

    resetn       = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    s_if.s_addr  = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset, a back-to-back in-range frame, then an out-of-range frame.
    sb.push_back(model(3, 32'hA5A5A5A5, 32'h0F0F0F0F, 2));
    sb.push_back(model(25, 32'h11111111, 32'h22222222, 2));
    for (int i = 0; i < 15; i++) begin
      resetn       = tbl[i].rstn;
      s_if.s_valid = tbl[i].valid;
      s_if.s_data  = tbl[i].data;
      s_if.s_addr  = tbl[i].addr;
      @(negedge clk);
      check($sformatf("v%0d_ready", i), {63'd0, s_if.s_ready}, {63'd0, tbl[i].ready});
      check($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, tbl[i].busy});
      check($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, tbl[i].err});
      check($sformatf("v%0d_strobe", i), {44'd0, frame_strobe}, {44'd0, tbl[i].strb});
      check($sformatf("v%0d_fd", i), frame_data, tbl[i].fd);
      @(posedge clk);
      #1;
    end
    s_if.s_valid = 1'b0;
    wait_drain();

    // Long valid gaps between beats stall in the load state.
    send_frame(9, 32'hCAFEF00D, 32'h12345678, 5, 1'b0, 2);
    wait_drain();

    // Reset asserted during the first strobe cycle.
    send_frame(5, 32'h55AA55AA, 32'hAA55AA55, 0, 1'b0, 1);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rst_mid_strobe_strobe", {44'd0, frame_strobe}, 64'd0);
    check("rst_mid_strobe_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_strobe_fd", frame_data, 64'd0);
    check("rst_mid_strobe_ready", {63'd0, s_if.s_ready}, 64'd1);
    @(posedge clk);
    #1;
    send_frame(12, 32'h0BADC0DE, 32'h600DF00D, 0, 1'b0, 2);
    wait_drain();

    // Two frames with valid held high: extreme addresses, minimum spacing.
    send_frame(0, 32'h01010101, 32'h02020202, 0, 1'b1, 2);
    send_frame(19, 32'h03030303, 32'h04040404, 0, 1'b0, 2);
    wait_drain();
    check("gap_between_frames", 64'(last_gap), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
